user_io_ctrl: RTL and testbench

- Wishbone-slave controller that owns the user GPIO pads inside the user project, placed between the management SoC Wishbone port and io_out/io_oeb/io_in.
- Firmware sets pad output values and output enables through registers, and reads synchronized pad inputs.
- Rising edges on enabled inputs latch sticky status bits; these status bits drive the user interrupt line.
- One instance serves up to 32 pads; the wrapper maps pad bits onto it.

---
 rtl/user_io_ctrl.sv | 135 +++++++++++++
 tb/tb_user_io_ctrl.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/user_io_ctrl.sv
// Wishbone-slave GPIO controller: pad outputs/enables, synchronized inputs,
// sticky rising-edge status with interrupt, and a saturating edge counter.
module user_io_ctrl #(
  parameter int unsigned     IO_W     = 32,
  parameter logic [31:0]     BASE_ADR = 32'h3000_0000,
  parameter logic [IO_W-1:0] OEB_RST  = '1
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_ni,
  input  logic            wbs_cyc_i,
  input  logic            wbs_stb_i,
  input  logic            wbs_we_i,
  input  logic [3:0]      wbs_sel_i,
  input  logic [31:0]     wbs_adr_i,
  input  logic [31:0]     wbs_dat_i,
  output logic            wbs_ack_o,
  output logic [31:0]     wbs_dat_o,
  input  logic [IO_W-1:0] io_in,
  output logic [IO_W-1:0] io_out,
  output logic [IO_W-1:0] io_oeb,
  output logic            irq_o
);

  logic            ack_q;
  logic [31:0]     dat_q;
  logic            irq_q;
  logic [IO_W-1:0] out_q, oeb_q, en_q, stat_q, stat_d;
  logic [IO_W-1:0] sync1_q, sync2_q, prev_q;
  logic [15:0]     cnt_q, cnt_d;

  logic            hit, ack_d, wr;
  logic [2:0]      idx;
  logic [31:0]     bmask;
  logic [IO_W-1:0] wmask, wdat, edge_v, clr;
  logic [5:0]      pop;
  logic [16:0]     sum;
  logic            cnt_clr;
  logic [31:0]     rdata;
  logic            unused_adr;

  assign unused_adr = ^wbs_adr_i[1:0];

  assign hit   = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:5] == BASE_ADR[31:5]);
  // One wait state; never two ack cycles in a row for a held strobe.
  assign ack_d = hit & ~ack_q;
  // Writes commit on the edge that raises ack, so registers show the new
  // value during the ack cycle.
  assign wr    = ack_d & wbs_we_i;
  assign idx   = wbs_adr_i[4:2];
  assign bmask = {{8{wbs_sel_i[3]}}, {8{wbs_sel_i[2]}}, {8{wbs_sel_i[1]}}, {8{wbs_sel_i[0]}}};
  assign wmask = bmask[IO_W-1:0];
  assign wdat  = wbs_dat_i[IO_W-1:0];

  assign edge_v  = sync2_q & ~prev_q & en_q;
  assign clr     = (wr && idx == 3'd4) ? (wmask & wdat) : '0;
  // Set wins over a same-cycle W1C.
  assign stat_d  = edge_v | (stat_q & ~clr);
  assign cnt_clr = wr && (idx == 3'd5) && (wbs_sel_i[0] | wbs_sel_i[1]);

  // Edge popcount and saturating counter next state
  always_comb begin
    pop = '0;
    for (int i = 0; i < int'(IO_W); i++) begin
      pop = pop + 6'(edge_v[i]);
    end
    sum = {1'b0, cnt_q} + 17'(pop);
    if (cnt_clr) begin
      cnt_d = 16'(pop);
    end else if (sum[16]) begin
      cnt_d = 16'hFFFF;
    end else begin
      cnt_d = sum[15:0];
    end
  end

  // Read mux; reserved offsets and bits above IO_W read as zero
  always_comb begin
    rdata = '0;
    case (idx)
      3'd0:    rdata[IO_W-1:0] = out_q;
      3'd1:    rdata[IO_W-1:0] = oeb_q;
      3'd2:    rdata[IO_W-1:0] = sync2_q;
      3'd3:    rdata[IO_W-1:0] = en_q;
      3'd4:    rdata[IO_W-1:0] = stat_q;
      3'd5:    rdata[15:0]     = cnt_q;
      default: rdata = '0;
    endcase
  end

  // Bus handshake, input synchronizer, status, counter and interrupt
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      ack_q   <= 1'b0;
      dat_q   <= '0;
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
      stat_q  <= '0;
      cnt_q   <= '0;
      irq_q   <= 1'b0;
    end else begin
      ack_q   <= ack_d;
      dat_q   <= (ack_d & ~wbs_we_i) ? rdata : '0;
      sync1_q <= io_in;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      stat_q  <= stat_d;
      cnt_q   <= cnt_d;
      irq_q   <= |(stat_q & en_q);
    end
  end

  // Firmware-writable configuration registers with byte-lane merge
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      out_q <= '0;
      oeb_q <= OEB_RST;
      en_q  <= '0;
    end else if (wr) begin
      case (idx)
        3'd0:    out_q <= (out_q & ~wmask) | (wdat & wmask);
        3'd1:    oeb_q <= (oeb_q & ~wmask) | (wdat & wmask);
        3'd3:    en_q  <= (en_q & ~wmask) | (wdat & wmask);
        default: ;
      endcase
    end
  end

  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = dat_q;
  assign io_out    = out_q;
  assign io_oeb    = oeb_q;
  assign irq_o     = irq_q;

endmodule

// File: tb/tb_user_io_ctrl.sv
// Directed self-checking bench for user_io_ctrl.
module tb_user_io_ctrl;

  localparam logic [31:0] BASE = 32'h3000_0000;

  logic        wb_clk_i = 1'b0;
  logic        clk_en   = 1'b0;
  logic        wb_rst_ni;
  logic        wbs_cyc_i, wbs_stb_i, wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i, wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;
  logic [31:0] io_in, io_out, io_oeb;
  logic        irq_o;

  int errors = 0;
  int checks = 0;

  user_io_ctrl dut (
    .wb_clk_i (wb_clk_i),
    .wb_rst_ni(wb_rst_ni),
    .wbs_cyc_i(wbs_cyc_i),
    .wbs_stb_i(wbs_stb_i),
    .wbs_we_i (wbs_we_i),
    .wbs_sel_i(wbs_sel_i),
    .wbs_adr_i(wbs_adr_i),
    .wbs_dat_i(wbs_dat_i),
    .wbs_ack_o(wbs_ack_o),
    .wbs_dat_o(wbs_dat_o),
    .io_in    (io_in),
    .io_out   (io_out),
    .io_oeb   (io_oeb),
    .irq_o    (irq_o)
  );

  always begin
    #5;
    if (clk_en) wb_clk_i = ~wb_clk_i;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Single bus access, entered and left on a negedge; lat=0 means no ack in 4 cycles.
  task automatic bus(input logic w, input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] s, output logic [31:0] rd, output int lat);
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = w;
    wbs_adr_i = a; wbs_dat_i = d; wbs_sel_i = s;
    lat = 0; rd = '0;
    for (int i = 1; i <= 4; i++) begin
      @(negedge wb_clk_i);
      if (wbs_ack_o === 1'b1) begin
        lat = i; rd = wbs_dat_o;
        break;
      end
    end
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
    @(negedge wb_clk_i);
  endtask

  task automatic pump(input int n);
    repeat (n) begin
      io_in = '1; @(negedge wb_clk_i);
      io_in = '0; @(negedge wb_clk_i);
    end
    repeat (4) @(negedge wb_clk_i);
  endtask

  task automatic test_reset();
    logic [31:0] rd; int lat;
    wb_rst_ni = 1'b1; wbs_cyc_i = 0; wbs_stb_i = 0; wbs_we_i = 0;
    wbs_sel_i = 0; wbs_adr_i = 0; wbs_dat_i = 0; io_in = 0;
    #3 wb_rst_ni = 1'b0;
    #1;
    checks++; if (wbs_ack_o !== 1'b0) begin errors++; $display("FAIL rst_ack: got %b want 0", wbs_ack_o); end
    checks++; if (wbs_dat_o !== 32'h0) begin errors++; $display("FAIL rst_dat: got %h want 0", wbs_dat_o); end
    checks++; if (io_oeb !== 32'hFFFF_FFFF) begin errors++; $display("FAIL rst_oeb: got %h want ffffffff", io_oeb); end
    checks++; if (io_out !== 32'h0) begin errors++; $display("FAIL rst_out: got %h want 0", io_out); end
    checks++; if (irq_o !== 1'b0) begin errors++; $display("FAIL rst_irq: got %b want 0", irq_o); end
    clk_en = 1'b1;
    repeat (2) @(negedge wb_clk_i);
    wb_rst_ni = 1'b1;
    @(negedge wb_clk_i);
    bus(1'b0, BASE + 32'h04, 0, 4'hF, rd, lat);
    checks++; if (rd !== 32'hFFFF_FFFF || lat !== 1) begin errors++; $display("FAIL rst_oeb_read: got %h lat %0d want ffffffff lat 1", rd, lat); end
  endtask

  task automatic test_out_write();
    logic [31:0] rd; int lat;
    bus(1'b1, BASE, 32'hAABB_CCDD, 4'b0101, rd, lat);
    checks++; if (lat !== 1) begin errors++; $display("FAIL out_ack_lat: got %0d want 1", lat); end
    checks++; if (io_out !== 32'h00BB_00DD) begin errors++; $display("FAIL out_pins: got %h want 00bb00dd", io_out); end
    bus(1'b0, BASE + 32'h01, 0, 4'hF, rd, lat);  // low address bits ignored
    checks++; if (rd !== 32'h00BB_00DD || lat !== 1) begin errors++; $display("FAIL out_read: got %h lat %0d want 00bb00dd lat 1", rd, lat); end
    bus(1'b1, BASE + 32'h04, 32'h1234_00FF, 4'b0011, rd, lat);
    checks++; if (io_oeb !== 32'hFFFF_00FF) begin errors++; $display("FAIL oeb_pins: got %h want ffff00ff", io_oeb); end
  endtask

  task automatic test_handshake();
    logic [31:0] rd; int lat; int acks; int consec; logic prev;
    wbs_cyc_i = 1; wbs_stb_i = 1; wbs_we_i = 0; wbs_sel_i = 4'hF; wbs_adr_i = BASE;
    acks = 0; consec = 0; prev = 1'b0;
    repeat (6) begin
      @(negedge wb_clk_i);
      if (wbs_ack_o === 1'b1) acks++;
      if (wbs_ack_o === 1'b1 && prev) consec++;
      prev = (wbs_ack_o === 1'b1);
    end
    wbs_cyc_i = 0; wbs_stb_i = 0;
    @(negedge wb_clk_i);
    checks++; if (acks !== 3) begin errors++; $display("FAIL held_stb_acks: got %0d want 3", acks); end
    checks++; if (consec !== 0) begin errors++; $display("FAIL held_stb_consec: got %0d want 0", consec); end
    bus(1'b0, BASE + 32'h40, 0, 4'hF, rd, lat);
    checks++; if (lat !== 0) begin errors++; $display("FAIL miss_ack: got lat %0d want 0", lat); end
    bus(1'b1, BASE + 32'h18, 32'hFFFF_FFFF, 4'hF, rd, lat);
    checks++; if (lat !== 1 || io_out !== 32'h00BB_00DD) begin errors++; $display("FAIL rsvd_write: lat %0d out %h want 1 00bb00dd", lat, io_out); end
    bus(1'b0, BASE + 32'h18, 0, 4'hF, rd, lat);
    checks++; if (rd !== 32'h0 || lat !== 1) begin errors++; $display("FAIL rsvd_read: got %h lat %0d want 0 lat 1", rd, lat); end
  endtask

  task automatic test_edge_irq();
    logic [31:0] rd; int lat;
    bus(1'b1, BASE + 32'h0C, 32'h8, 4'hF, rd, lat);
    io_in[3] = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge wb_clk_i);
      checks++; if (irq_o !== (k == 4)) begin errors++; $display("FAIL edge_irq_t%0d: got %b want %b", k, irq_o, (k == 4)); end
    end
    bus(1'b0, BASE + 32'h10, 0, 4'hF, rd, lat);
    checks++; if (rd !== 32'h8) begin errors++; $display("FAIL edge_stat: got %h want 8", rd); end
    bus(1'b0, BASE + 32'h14, 0, 4'hF, rd, lat);
    checks++; if (rd !== 32'h1) begin errors++; $display("FAIL edge_cnt: got %h want 1", rd); end
    bus(1'b0, BASE + 32'h08, 0, 4'hF, rd, lat);
    checks++; if (rd !== 32'h8) begin errors++; $display("FAIL in_read: got %h want 8", rd); end
    bus(1'b1, BASE + 32'h10, 32'h8, 4'hF, rd, lat);
    checks++; if (irq_o !== 1'b0) begin errors++; $display("FAIL w1c_irq: got %b want 0", irq_o); end
    bus(1'b0, BASE + 32'h10, 0, 4'hF, rd, lat);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL w1c_stat: got %h want 0", rd); end
  endtask

  task automatic test_set_wins();
    logic [31:0] rd; int lat;
    io_in[3] = 1'b0; repeat (4) @(negedge wb_clk_i);
    io_in[3] = 1'b1; repeat (5) @(negedge wb_clk_i);
    io_in[3] = 1'b0; repeat (4) @(negedge wb_clk_i);
    // Rise now; the edge is live on the third clock, when the W1C commits.
    io_in[3] = 1'b1;
    repeat (2) @(negedge wb_clk_i);
    bus(1'b1, BASE + 32'h10, 32'h8, 4'hF, rd, lat);
    checks++; if (irq_o !== 1'b1) begin errors++; $display("FAIL setwins_irq: got %b want 1", irq_o); end
    bus(1'b0, BASE + 32'h10, 0, 4'hF, rd, lat);
    checks++; if (rd !== 32'h8) begin errors++; $display("FAIL setwins_stat: got %h want 8", rd); end
    bus(1'b0, BASE + 32'h14, 0, 4'hF, rd, lat);
    checks++; if (rd !== 32'h3) begin errors++; $display("FAIL setwins_cnt: got %h want 3", rd); end
    bus(1'b1, BASE + 32'h0C, 32'h0, 4'hF, rd, lat);
    checks++; if (irq_o !== 1'b0) begin errors++; $display("FAIL mask_irq: got %b want 0", irq_o); end
    io_in[3] = 1'b0; repeat (3) @(negedge wb_clk_i);
    io_in[3] = 1'b1; repeat (5) @(negedge wb_clk_i);
    bus(1'b0, BASE + 32'h10, 0, 4'hF, rd, lat);
    checks++; if (rd !== 32'h8) begin errors++; $display("FAIL mask_stat: got %h want 8", rd); end
    bus(1'b0, BASE + 32'h14, 0, 4'hF, rd, lat);
    checks++; if (rd !== 32'h3) begin errors++; $display("FAIL mask_cnt: got %h want 3", rd); end
  endtask

  task automatic test_cnt_saturate();
    logic [31:0] rd; int lat;
    io_in = '0; repeat (4) @(negedge wb_clk_i);
    bus(1'b1, BASE + 32'h0C, 32'hFFFF_FFFF, 4'hF, rd, lat);
    bus(1'b1, BASE + 32'h14, 32'h0, 4'b0001, rd, lat);
    bus(1'b0, BASE + 32'h14, 0, 4'hF, rd, lat);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL cnt_clear0: got %h want 0", rd); end
    pump(2047);  // 2047 rises x 32 pads
    bus(1'b0, BASE + 32'h14, 0, 4'hF, rd, lat);
    checks++; if (rd !== 32'd65504) begin errors++; $display("FAIL cnt_65504: got %h want ffe0", rd); end
    bus(1'b1, BASE + 32'h0C, 32'h7FFF_FFFF, 4'hF, rd, lat);
    pump(1);
    bus(1'b0, BASE + 32'h14, 0, 4'hF, rd, lat);
    checks++; if (rd !== 32'h0000_FFFF) begin errors++; $display("FAIL cnt_max: got %h want ffff", rd); end
    bus(1'b1, BASE + 32'h0C, 32'hFFFF_FFFF, 4'hF, rd, lat);
    pump(3);
    bus(1'b0, BASE + 32'h14, 0, 4'hF, rd, lat);
    checks++; if (rd !== 32'h0000_FFFF) begin errors++; $display("FAIL cnt_sat: got %h want ffff", rd); end
    bus(1'b1, BASE + 32'h14, 32'h0, 4'b1100, rd, lat);
    bus(1'b0, BASE + 32'h14, 0, 4'hF, rd, lat);
    checks++; if (rd !== 32'h0000_FFFF) begin errors++; $display("FAIL cnt_upper_sel: got %h want ffff", rd); end
    bus(1'b1, BASE + 32'h14, 32'hFFFF_FFFF, 4'b0010, rd, lat);
    bus(1'b0, BASE + 32'h14, 0, 4'hF, rd, lat);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL cnt_clear: got %h want 0", rd); end
  endtask

  initial begin
    test_reset();
    test_out_write();
    test_handshake();
    test_edge_irq();
    test_set_wins();
    test_cnt_saturate();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
